// File: rtl/arith_op_scheduler.sv
// -----------------------------------------------------------------------------
// arith_op_scheduler
//
// Purpose:
//   Shares one 8-bit arithmetic unit (add, sub, mul, div/mod) among N_REQ
//   requesters. A round-robin arbiter grants one requester per operation.
//   Add/sub/mul finish in a single execute cycle. Division with a non-zero
//   divisor runs an 8-iteration restoring divider. Each result is tagged with
//   the issuing requester's index and held until the consumer accepts it.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   ID_W   width of rsp_id, 2**ID_W >= N_REQ
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   per-requester operation valid
//   req_ready   per-requester accept, one-hot or zero, only in IDLE
//   req_a       operand A, 8 bits per requester
//   req_b       operand B, 8 bits per requester
//   req_sel     op select per requester: 00 add, 01 sub, 10 mul, 11 div
//   rsp_valid   result available
//   rsp_ready   consumer accepts the result
//   rsp_id      index of the requester that issued the op
//   rsp_c       sum, difference, product or quotient
//   rsp_rem     remainder, 0 for non-div ops
//   rsp_div0    divide-by-zero flag
//   busy        high whenever the scheduler is not IDLE
//
// Optional feature (macro ARITH_SCHED_STATS_EN):
//   op_count    saturating count of response handshakes (16 bits)
//   div0_count  saturating count of handshakes carrying rsp_div0 (8 bits)
// -----------------------------------------------------------------------------
module arith_op_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_a,
    input  logic [8*N_REQ-1:0]   req_b,
    input  logic [2*N_REQ-1:0]   req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          rsp_c,
    output logic [7:0]           rsp_rem,
    output logic                 rsp_div0,
    output logic                 busy
`ifdef ARITH_SCHED_STATS_EN
    ,
    output logic [15:0]          op_count,
    output logic [7:0]           div0_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DIV  = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;

    logic [ID_W-1:0]   ptr_r;
    logic [7:0]        a_r;          // operand A; doubles as dividend/quotient shift register
    logic [7:0]        b_r;
    logic [1:0]        sel_r;
    logic [ID_W-1:0]   id_r;
    logic [7:0]        rem_r;        // partial remainder of the divider
    logic [2:0]        cnt_r;        // divider iteration index

    logic              rsp_valid_r;
    logic [ID_W-1:0]   rsp_id_r;
    logic [15:0]       rsp_c_r;
    logic [7:0]        rsp_rem_r;
    logic              rsp_div0_r;
    logic              busy_r;

    logic              found_s;
    logic [ID_W-1:0]   win_s;
    logic [N_REQ-1:0]  grant_s;
    logic [7:0]        win_a_s;
    logic [7:0]        win_b_s;
    logic [1:0]        win_sel_s;
    logic [ID_W-1:0]   ptr_nx_s;

    logic [8:0]        shifted_s;
    logic              ge_s;
    logic [7:0]        diff_s;
    logic [7:0]        rem_nx_s;
    logic [7:0]        quo_nx_s;

    logic [15:0]       exec_c_s;
    logic [7:0]        exec_rem_s;
    logic              exec_div0_s;

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        logic [ID_W:0] idx_s;
        logic          hit_s;
        found_s = 1'b0;
        win_s   = {ID_W{1'b0}};
        idx_s   = {(ID_W+1){1'b0}};
        hit_s   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s   = {1'b0, ptr_r} + (ID_W+1)'(k);
            idx_s   = (idx_s >= (ID_W+1)'(N_REQ)) ? (idx_s - (ID_W+1)'(N_REQ)) : idx_s;
            hit_s   = !found_s && req_valid[idx_s[ID_W-1:0]];
            win_s   = hit_s ? idx_s[ID_W-1:0] : win_s;
            found_s = found_s | hit_s;
        end
    end

    // One-hot grant vector and the winner's operands (AND-OR mux on the grant).
    always_comb begin
        grant_s   = {N_REQ{1'b0}};
        win_a_s   = 8'h00;
        win_b_s   = 8'h00;
        win_sel_s = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            grant_s[i] = found_s && (win_s == ID_W'(i));
            win_a_s    = win_a_s   | (req_a[i*8 +: 8]   & {8{grant_s[i]}});
            win_b_s    = win_b_s   | (req_b[i*8 +: 8]   & {8{grant_s[i]}});
            win_sel_s  = win_sel_s | (req_sel[i*2 +: 2] & {2{grant_s[i]}});
        end
    end

    // Pointer moves just past the winner, wrapping after the last requester.
    always_comb begin
        if (win_s == ID_W'(N_REQ - 1)) begin
            ptr_nx_s = {ID_W{1'b0}};
        end else begin
            ptr_nx_s = win_s + ID_W'(1);
        end
    end

    // Grants are only offered in IDLE; reset forces them low immediately.
    always_comb begin
        if ((state_r == IDLE) && !rst) begin
            req_ready = grant_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract.
    always_comb begin
        shifted_s = {rem_r, a_r[7]};
        ge_s      = (shifted_s >= {1'b0, b_r});
        diff_s    = shifted_s[7:0] - b_r;
        rem_nx_s  = ge_s ? diff_s : shifted_s[7:0];
        quo_nx_s  = {a_r[6:0], ge_s};
    end

    // Single-cycle results; a div reaching EXEC always has a zero divisor.
    always_comb begin
        exec_c_s    = 16'h0000;
        exec_rem_s  = 8'h00;
        exec_div0_s = 1'b0;
        case (sel_r)
            2'b00: exec_c_s = {8'h00, a_r} + {8'h00, b_r};
            2'b01: exec_c_s = {8'h00, a_r} - {8'h00, b_r};
            2'b10: exec_c_s = {8'h00, a_r} * {8'h00, b_r};
            2'b11: begin
                exec_c_s    = 16'hFFFF;
                exec_rem_s  = a_r;
                exec_div0_s = 1'b1;
            end
            default: begin
                exec_c_s    = 16'h0000;
                exec_rem_s  = 8'h00;
                exec_div0_s = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = ((win_sel_s == 2'b11) && (win_b_s != 8'h00)) ? DIV : EXEC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC: state_nx_s = RESP;
            DIV: begin
                if (cnt_r == 3'd7) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = DIV;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Operand capture, divider iterations and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= {ID_W{1'b0}};
            a_r         <= 8'h00;
            b_r         <= 8'h00;
            sel_r       <= 2'b00;
            id_r        <= {ID_W{1'b0}};
            rem_r       <= 8'h00;
            cnt_r       <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_c_r     <= 16'h0000;
            rsp_rem_r   <= 8'h00;
            rsp_div0_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        a_r   <= win_a_s;
                        b_r   <= win_b_s;
                        sel_r <= win_sel_s;
                        id_r  <= win_s;
                        ptr_r <= ptr_nx_s;
                        rem_r <= 8'h00;
                        cnt_r <= 3'd0;
                    end
                end
                EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_c_r     <= exec_c_s;
                    rsp_rem_r   <= exec_rem_s;
                    rsp_div0_r  <= exec_div0_s;
                end
                DIV: begin
                    a_r   <= quo_nx_s;
                    rem_r <= rem_nx_s;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_c_r     <= {8'h00, quo_nx_s};
                        rsp_rem_r   <= rem_nx_s;
                        rsp_div0_r  <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_c     = rsp_c_r;
    assign rsp_rem   = rsp_rem_r;
    assign rsp_div0  = rsp_div0_r;
    assign busy      = busy_r;

`ifdef ARITH_SCHED_STATS_EN
    logic        handshake_s;
    logic [15:0] op_count_r;
    logic [7:0]  div0_count_r;

    assign handshake_s = rsp_valid_r && rsp_ready;

    // Saturating statistics counters, advanced on each response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_r   <= 16'h0000;
            div0_count_r <= 8'h00;
        end else begin
            if (handshake_s && (op_count_r != 16'hFFFF)) begin
                op_count_r <= op_count_r + 16'd1;
            end
            if (handshake_s && rsp_div0_r && (div0_count_r != 8'hFF)) begin
                div0_count_r <= div0_count_r + 8'd1;
            end
        end
    end

    assign op_count   = op_count_r;
    assign div0_count = div0_count_r;
`endif

endmodule

// File: tb/tb_arith_op_scheduler.sv
module tb_arith_op_scheduler;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [8*N_REQ-1:0] req_a;
    logic [8*N_REQ-1:0] req_b;
    logic [2*N_REQ-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [15:0]       rsp_c;
    logic [7:0]        rsp_rem;
    logic              rsp_div0;
    logic              busy;
`ifdef ARITH_SCHED_STATS_EN
    logic [15:0]       op_count;
    logic [7:0]        div0_count;
`endif

    // {id, c, rem, div0}
    typedef logic [26:0] rsp_t;
    rsp_t sb[$];

    int checks   = 0;
    int failures = 0;

    arith_op_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .rsp_rem   (rsp_rem),
        .rsp_div0  (rsp_div0),
        .busy      (busy)
`ifdef ARITH_SCHED_STATS_EN
        ,
        .op_count  (op_count),
        .div0_count(div0_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic rsp_t model(input int id, input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] sel);
        logic [15:0] c;
        logic [7:0]  r;
        logic        d;
        logic [1:0]  idv;
        c = 16'h0000; r = 8'h00; d = 1'b0;
        idv = id[1:0];
        case (sel)
            2'b00: c = 16'(a) + 16'(b);
            2'b01: c = 16'(a) - 16'(b);
            2'b10: c = 16'(a) * 16'(b);
            default: begin
                if (b == 8'h00) begin
                    c = 16'hFFFF; r = a; d = 1'b1;
                end else begin
                    c = 16'(a / b); r = a % b;
                end
            end
        endcase
        return {idv, c, r, d};
    endfunction

    function automatic rsp_t pop_exp();
        rsp_t e;
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drive a request, wait for its grant; returns one cycle after the accept.
    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] sel, output bit ok);
        int n;
        req_a[id*8 +: 8]   = a;
        req_b[id*8 +: 8]   = b;
        req_sel[id*2 +: 2] = sel;
        req_valid[id]      = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready[id] === 1'b1);
        if (ok) begin
            sb.push_back(model(id, a, b, sel));
            @(negedge clk);
        end
        req_valid[id] = 1'b0;
    endtask

    // Cycles since the accept cycle until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        req_a = '0; req_b = '0; req_sel = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, busy, req_ready} !== 33'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, busy, req_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=00", {rsp_valid, busy});
        end
    endtask

    task automatic test_add();
        bit ok; int lat; rsp_t e;
        rsp_ready = 1'b1;
        issue(0, 8'd200, 8'd100, 2'b00, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL add_grant got=none want=req0"); end
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d want=2", lat); end
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL add_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL add_release got=%b want=00", {rsp_valid, busy});
        end
    endtask

    task automatic test_sub_mul();
        bit ok; int lat; rsp_t e;
        logic [7:0] av [2];
        logic [7:0] bv [2];
        logic [1:0] sv [2];
        av[0] = 8'd3;   bv[0] = 8'd5;   sv[0] = 2'b01;
        av[1] = 8'd255; bv[1] = 8'd255; sv[1] = 2'b10;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(1, av[k], bv[k], sv[k], ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL submul_grant[%0d] got=none want=req1", k); end
            wait_rsp(lat);
            checks++;
            if (lat !== 2) begin failures++; $display("FAIL submul_latency[%0d] got=%0d want=2", k, lat); end
            e = pop_exp();
            checks++;
            if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
                failures++;
                $display("FAIL submul_result[%0d] got=%h want=%h", k,
                         {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        bit ok; int lat; rsp_t e;
        rsp_ready = 1'b1;
        issue(2, 8'd200, 8'd7, 2'b11, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL div_grant got=none want=req2"); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL div_busy got=%b want=1", busy); end
        wait_rsp(lat);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL div_latency got=%0d want=9", lat); end
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL div_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        @(negedge clk);
        issue(2, 8'd9, 8'd0, 2'b11, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL div0_grant got=none want=req2"); end
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL div0_latency got=%0d want=2", lat); end
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL div0_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [7:0] ra [4];
        logic [7:0] rb [4];
        int order [5];
        int ngrant, cyc, win;
        rsp_t e;
        ra[0] = 8'd10; ra[1] = 8'd30; ra[2] = 8'd50; ra[3] = 8'd70;
        rb[0] = 8'd3;  rb[1] = 8'd4;  rb[2] = 8'd5;  rb[3] = 8'd6;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8]   = ra[i];
            req_b[i*8 +: 8]   = rb[i];
            req_sel[i*2 +: 2] = 2'(i);
            order[i] = -1;
        end
        order[4] = -1;
        req_valid = 4'hF;
        #1;
        ngrant = 0;
        cyc = 0;
        while ((ngrant < 5 || sb.size() > 0) && cyc < 200) begin
            if (ngrant == 5) req_valid = 4'h0;
            checks++;
            if ($countones(req_ready) > 1) begin
                failures++;
                $display("FAIL rr_onehot got=%b want=at most one bit", req_ready);
            end
            if (req_ready != 4'h0 && ngrant < 5) begin
                win = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) win = i;
                order[ngrant] = win;
                sb.push_back(model(win, ra[win], rb[win], 2'(win)));
                ngrant++;
            end
            if (rsp_valid === 1'b1) begin
                e = pop_exp();
                checks++;
                if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
                    failures++;
                    $display("FAIL rr_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 4'h0;
        checks++;
        if (cyc >= 200) begin failures++; $display("FAIL rr_timeout got=%0d grants want=5", ngrant); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (order[k] !== k % 4) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%0d want=%0d", k, order[k], k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok; int lat; rsp_t e;
        rsp_ready = 1'b0;
        issue(1, 8'd7, 8'd8, 2'b00, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_grant got=none want=req1"); end
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL bp_latency got=%0d want=2", lat); end
        req_a[0*8 +: 8] = 8'd1;  req_b[0*8 +: 8] = 8'd1;  req_sel[0*2 +: 2] = 2'b00;
        req_a[2*8 +: 8] = 8'd50; req_b[2*8 +: 8] = 8'd20; req_sel[2*2 +: 2] = 2'b01;
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        #1;
        if (sb.size() > 0) e = sb[0];
        else e = 'x;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, req_ready} !== {1'b1, e, 4'h0}) begin
                failures++;
                $display("FAIL bp_hold[%0d] got=%h want=%h", k,
                         {rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, req_ready}, {1'b1, e, 4'h0});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL bp_handshake_cycle got=%b want=10000", {rsp_valid, req_ready});
        end
        e = pop_exp();
        @(negedge clk);
        checks++;
        if ({rsp_valid, req_ready} !== 5'b00100) begin
            failures++;
            $display("FAIL bp_next_accept got=%b want=00100", {rsp_valid, req_ready});
        end
        sb.push_back(model(2, 8'd50, 8'd20, 2'b01));
        @(negedge clk);
        req_valid = 4'h0;
        wait_rsp(lat);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL bp_req2_latency got=%0d want=2", lat); end
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL bp_req2_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div();
        bit ok; int lat; rsp_t e;
        do_reset();
        rsp_ready = 1'b1;
        issue(2, 8'd100, 8'd3, 2'b11, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rmd_grant got=none want=req2"); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rsp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL rmd_in_div got=%b want=10", {busy, rsp_valid});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, busy, req_ready} !== 33'h0) begin
            failures++;
            $display("FAIL rmd_reset_outputs got=%h want=0",
                     {rsp_valid, rsp_id, rsp_c, rsp_rem, rsp_div0, busy, req_ready});
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        req_a[1*8 +: 8] = 8'd5; req_b[1*8 +: 8] = 8'd6; req_sel[1*2 +: 2] = 2'b10;
        req_a[3*8 +: 8] = 8'd9; req_b[3*8 +: 8] = 8'd2; req_sel[3*2 +: 2] = 2'b11;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL rmd_pointer_cleared got=%b want=0010", req_ready);
        end
        sb.push_back(model(1, 8'd5, 8'd6, 2'b10));
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL rmd_req1_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        issue(3, 8'd9, 8'd2, 2'b11, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rmd_req3_grant got=none want=req3"); end
        wait_rsp(lat);
        checks++;
        if (lat !== 9) begin failures++; $display("FAIL rmd_req3_latency got=%0d want=9", lat); end
        e = pop_exp();
        checks++;
        if ({rsp_id, rsp_c, rsp_rem, rsp_div0} !== e) begin
            failures++;
            $display("FAIL rmd_req3_result got=%h want=%h", {rsp_id, rsp_c, rsp_rem, rsp_div0}, e);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mul();
        test_div();
        test_round_robin();
        test_backpressure();
        test_reset_mid_div();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
